// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Pipelined barrel shifter for the R-type datapath. Supports SLL, SRL, SRA
// and ROR over WIDTH bits in log2(WIDTH) mux levels. Level k shifts by 2^k,
// and levels are applied in ascending order. A register stage follows every
// LEVELS_PER_STAGE levels. The whole pipe stalls while the output is valid
// and not accepted. A sideband tag travels with each operation.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   input operation valid
//   in_ready   block accepts input this cycle (= pipe advances)
//   in_data    operand to shift
//   in_shamt   shift amount, log2(WIDTH) bits
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag     sideband tag, returned with the result
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   shifted result
//   out_tag    tag of this result
//   out_zero   out_data == 0, registered with out_data
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
   parameter int WIDTH            = 32,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int TAG_W            = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [1:0]               in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_zero
);

   localparam int SHW     = $clog2(WIDTH);
   localparam int NSTAGES = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // One mux level: shift by amt (a power of two) according to op.
   function automatic logic [WIDTH-1:0] shift_level(
      input logic [WIDTH-1:0] d,
      input op_e              op,
      input logic             sign,
      input int unsigned      amt
   );
      logic [WIDTH-1:0] fill_mask;
      fill_mask = ~({WIDTH{1'b1}} >> amt);
      case (op)
         OP_SLL:  return d << amt;
         OP_SRL:  return d >> amt;
         OP_SRA:  return (d >> amt) | (sign ? fill_mask : '0);
         default: return (d >> amt) | (d << (WIDTH - amt));
      endcase
   endfunction

   for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic [TAG_W-1:0] tag_q;

      logic             src_valid;
      logic [WIDTH-1:0] src_data;
      logic [SHW-1:0]   src_shamt;
      op_e              src_op;
      logic             src_sign;
      logic [TAG_W-1:0] src_tag;
      logic [WIDTH-1:0] data_d;

      if (s == 0) begin : g_src
         assign src_valid = in_valid;
         assign src_data  = in_data;
         assign src_shamt = in_shamt;
         assign src_op    = op_e'(in_op);
         // SRA fill is the operand's original sign, fixed at acceptance.
         assign src_sign  = in_data[WIDTH-1];
         assign src_tag   = in_tag;
      end else begin : g_src
         assign src_valid = g_stage[s-1].valid_q;
         assign src_data  = g_stage[s-1].data_q;
         assign src_shamt = g_stage[s-1].g_ctl.shamt_q;
         assign src_op    = g_stage[s-1].g_ctl.op_q;
         assign src_sign  = g_stage[s-1].g_ctl.sign_q;
         assign src_tag   = g_stage[s-1].tag_q;
      end

      // Levels s*LPS .. s*LPS+LPS-1; levels at or above SHW select nothing
      // because the shamt bit mask shifts out to zero.
      always_comb begin
         int unsigned k;
         k      = 0;
         data_d = src_data;
         for (int unsigned l = 0; l < LEVELS_PER_STAGE; l++) begin
            k = s * LEVELS_PER_STAGE + l;
            if (|(src_shamt & (SHW'(1) << k)))
               data_d = shift_level(data_d, src_op, src_sign, 32'd1 << k);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
         end else if (advance) begin
            valid_q <= src_valid;
            data_q  <= data_d;
            tag_q   <= src_tag;
         end
      end

      // Shift control is only needed by later stages; the last stage keeps
      // just the result. Already-consumed shamt bits are carried but never
      // read, so they drop out in synthesis.
      if (s < NSTAGES - 1) begin : g_ctl
         logic [SHW-1:0] shamt_q;
         op_e            op_q;
         logic           sign_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               shamt_q <= '0;
               op_q    <= OP_SLL;
               sign_q  <= 1'b0;
            end else if (advance) begin
               shamt_q <= src_shamt;
               op_q    <= src_op;
               sign_q  <= src_sign;
            end
         end
      end
   end

   logic zero_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q <= 1'b0;
      end else if (advance) begin
         zero_q <= (g_stage[NSTAGES-1].data_d == '0);
      end
   end

   assign out_valid = g_stage[NSTAGES-1].valid_q;
   assign out_data  = g_stage[NSTAGES-1].data_q;
   assign out_tag   = g_stage[NSTAGES-1].tag_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
//
// Directed bench for pipelined_barrel_shifter (WIDTH=32, LPS=2, TAG_W=5).
// Stimulus pushes hand-computed expected results into a queue on every
// accepted input; a negedge monitor pops and compares on every output
// transfer.
// ---------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

   localparam logic [1:0] SLL = 2'b00;
   localparam logic [1:0] SRL = 2'b01;
   localparam logic [1:0] SRA = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        out_zero;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   int   pop_cyc[$];
   int   cyc = 0;
   int   acc_cyc = 0;
   int   last_pop_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   pipelined_barrel_shifter #(
      .WIDTH(32),
      .LEVELS_PER_STAGE(2),
      .TAG_W(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_shamt(in_shamt),
      .in_op(in_op),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_tag(out_tag),
      .out_zero(out_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Entered and left at posedge+1.
   task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                       input logic [4:0] tag, input logic [31:0] exp_data);
      bit done;
      done     = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_shamt = sh;
      in_tag   = tag;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{data: exp_data, tag: tag});
            acc_cyc = cyc;
            done    = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) timeout_fail("send_accept");
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) timeout_fail("drain");
      @(posedge clk); #1;
   endtask

   // Monitor: one scoreboard pop per output transfer.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got data=%h tag=%0d, required no output (cycle %0d)",
                     out_data, out_tag, cyc);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", 32'(out_tag), 32'(e.tag));
            check("out_zero", 32'(out_zero), 32'(e.data == 32'h0));
            last_pop_cyc = cyc;
            pop_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_op     = SLL;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // First op and latency
      send(SRL, 32'h8000_0000, 5'd31, 5'd3, 32'h0000_0001);
      drain();
      check("latency", 32'(last_pop_cyc - acc_cyc), 32'd3);

      // Directed vectors, issued back to back
      send(SRA, 32'h8000_0000, 5'd4,  5'd4,  32'hF800_0000);
      send(SLL, 32'h0000_000F, 5'd28, 5'd5,  32'hF000_0000);
      send(ROR, 32'h0000_0001, 5'd1,  5'd6,  32'h8000_0000);
      send(SLL, 32'hFFFF_FFFF, 5'd0,  5'd7,  32'hFFFF_FFFF);
      send(SRL, 32'h0000_0001, 5'd1,  5'd8,  32'h0000_0000);
      send(ROR, 32'h1234_5678, 5'd8,  5'd9,  32'h7812_3456);
      send(SRA, 32'h7FFF_FFF0, 5'd4,  5'd10, 32'h07FF_FFFF);
      send(ROR, 32'h8000_0001, 5'd31, 5'd11, 32'h0000_0003);
      send(SRA, 32'h8000_0000, 5'd31, 5'd12, 32'hFFFF_FFFF);
      send(SRL, 32'hDEAD_BEEF, 5'd0,  5'd13, 32'hDEAD_BEEF);
      send(ROR, 32'hA5A5_A5A5, 5'd0,  5'd14, 32'hA5A5_A5A5);
      drain();

      // Back-to-back stream, shamt 0..9
      pop_cyc.delete();
      for (int i = 0; i < 10; i++)
         send(SLL, 32'h0000_0001, 5'(i), 5'(16 + i), 32'h0000_0001 << i);
      drain();
      check("stream_count", 32'(pop_cyc.size()), 32'd10);
      if (pop_cyc.size() == 10)
         check("stream_consecutive", 32'(pop_cyc[9] - pop_cyc[0]), 32'd9);

      // Stall: hold out_ready low with three ops in the pipe
      out_ready = 1'b0;
      send(SRL, 32'hF000_0000, 5'd4, 5'd20, 32'h0F00_0000);
      send(SRA, 32'h8000_0000, 5'd1, 5'd21, 32'hC000_0000);
      send(ROR, 32'h0000_000F, 5'd4, 5'd22, 32'hF000_0000);
      in_valid = 1'b1;
      in_op    = SLL;
      in_data  = 32'h0000_0001;
      in_shamt = 5'd31;
      in_tag   = 5'd23;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_data", out_data, 32'h0F00_0000);
         check("stall_out_tag", 32'(out_tag), 32'd20);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(SLL, 32'h0000_0001, 5'd31, 5'd23, 32'h8000_0000);
      drain();
      check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with three ops in flight
      send(SLL, 32'h0000_0003, 5'd2, 5'd30, 32'h0000_000C);
      send(SRL, 32'h0000_0030, 5'd4, 5'd31, 32'h0000_0003);
      send(ROR, 32'h0000_0002, 5'd1, 5'd29, 32'h0000_0001);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", out_data, 32'h0);
      check("mid_rst_out_tag", 32'(out_tag), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (8) @(negedge clk);
      check("post_rst_no_output", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
